// File: rtl/tt_um_serial_adder_acc.sv
// rtl/tt_um_serial_adder_acc.sv - bit-serial adder/accumulator on the Tiny Tapeout tile pinout
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module tt_um_serial_adder_acc #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, b, sa, sb, s, r, sum_final;
    logic [CW-1:0]    cnt;
    logic             c, c_flag, v_flag, start_q, acc_q;
    logic             start_edge, last_bit, bit_s, bit_c, sub_req;
    logic             unused;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_req = uio_in[4];
`else
    assign sub_req = 1'b0;
`endif

    assign unused     = &{1'b0, ena, ui_in, uio_in};
    assign start_edge = uio_in[0] & ~start_q;
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    assign bit_s      = sa[0] ^ sb[0] ^ c;
    assign bit_c      = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign sum_final  = {bit_s, s[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            b       <= '0;
            sa      <= '0;
            sb      <= '0;
            s       <= '0;
            r       <= '0;
            cnt     <= '0;
            c       <= 1'b0;
            c_flag  <= 1'b0;
            v_flag  <= 1'b0;
            start_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            start_q <= uio_in[0];
            case (state)
                IDLE: begin
                    // A start edge takes priority over any load in the same cycle
                    if (start_edge) begin
                        sa    <= a;
                        sb    <= sub_req ? ~b : b;
                        c     <= sub_req;
                        cnt   <= '0;
                        acc_q <= uio_in[3];
                    end else begin
                        if (uio_in[1]) a <= ui_in[WIDTH-1:0];
                        if (uio_in[2]) b <= ui_in[WIDTH-1:0];
                    end
                end
                RUN: begin
                    s   <= sum_final;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= bit_c;
                    cnt <= cnt + CW'(1);
                    // On the last bit sa[0]/sb[0] are the operand MSBs and bit_s the sum MSB
                    if (last_bit) begin
                        r      <= sum_final;
                        c_flag <= bit_c;
                        v_flag <= (sa[0] == sb[0]) && (bit_s != sa[0]);
                        if (acc_q) a <= sum_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = 8'(r);
    assign uio_out = {v_flag, c_flag, (state == DONE), (state == RUN), 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_serial_adder_acc.sv
// tb/tb_tt_um_serial_adder_acc.sv - randomized self-checking bench for tt_um_serial_adder_acc
module tb_tt_um_serial_adder_acc;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int total = 0;
    int bad   = 0;
    int m_a, m_b, m_r, m_c, m_v;

    tt_um_serial_adder_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic calc(input bit sub, output int sum, output int cy, output int ov);
        int sa_i, sb_i, res;
        sa_i = (m_a > 127) ? m_a - 256 : m_a;
        sb_i = (m_b > 127) ? m_b - 256 : m_b;
        if (sub) begin
            sum = (m_a - m_b + 256) % 256;
            cy  = (m_a >= m_b) ? 1 : 0;
            res = sa_i - sb_i;
        end else begin
            sum = (m_a + m_b) % 256;
            cy  = (m_a + m_b > 255) ? 1 : 0;
            res = sa_i + sb_i;
        end
        ov = (res > 127 || res < -128) ? 1 : 0;
    endtask

    task automatic load(input bit sel_b, input bit both, input logic [7:0] v);
        @(negedge clk);
        ui_in  = v;
        uio_in = both ? 8'h06 : (sel_b ? 8'h04 : 8'h02);
        @(negedge clk);
        uio_in = 8'h00;
        if (both || !sel_b) m_a = v;
        if (both || sel_b) m_b = v;
    endtask

    task automatic do_op(input bit acc, input bit sub, input bit mid_load);
        int n, e_sum, e_c, e_v;
        bit sub_eff;
        sub_eff = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_eff = sub;
`endif
        calc(sub_eff, e_sum, e_c, e_v);
        @(negedge clk);
        uio_in = {3'b000, sub, acc, 3'b001};
        @(posedge clk);
        #1;
        uio_in[0] = 1'b0;
        check("busy_e0", uio_out[4], 1);
        n = 0;
        while (uio_out[5] !== 1'b1 && n < 40) begin
            check("run_stable", {uio_out[4], uo_out}, {1'b1, m_r[7:0]});
            if (mid_load && n == 3) begin
                uio_in[1] = 1'b1;
                ui_in     = 8'hA5;
            end else begin
                uio_in[1] = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        uio_in[1] = 1'b0;
        check("latency", n, W);
        check("result", uo_out, e_sum);
        check("carry", uio_out[6], e_c);
        check("overflow", uio_out[7], e_v);
        check("busy_at_done", uio_out[4], 0);
        m_r = e_sum;
        m_c = e_c;
        m_v = e_v;
        if (acc) m_a = e_sum;
        @(posedge clk);
        #1;
        check("done_pulse", uio_out[5], 0);
    endtask

    initial begin
        int dones;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_a = 0; m_b = 0; m_r = 0; m_c = 0; m_v = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        load(0, 0, 8'h0F); load(1, 0, 8'h01); do_op(0, 0, 0);
        check("d_0f01", {uio_out[7:6], uo_out}, {2'b00, 8'h10});
        load(0, 0, 8'hFF); do_op(0, 0, 0);
        check("d_ff01", {uio_out[7:6], uo_out}, {2'b01, 8'h00});
        load(0, 0, 8'h7F); do_op(0, 0, 0);
        check("d_7f01", {uio_out[7:6], uo_out}, {2'b10, 8'h80});

        load(0, 0, 8'h05); load(1, 0, 8'h03);
        do_op(1, 0, 0); check("acc1", uo_out, 8'h08);
        do_op(1, 0, 0); check("acc2", uo_out, 8'h0B);
        do_op(1, 0, 0); check("acc3", uo_out, 8'h0E);

        load(0, 0, 8'h12); load(1, 0, 8'h34);
        dones = 0;
        @(negedge clk);
        uio_in = 8'h01;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[5] === 1'b1) dones++;
        end
        uio_in = 8'h00;
        @(posedge clk);
        check("held_start_dones", dones, 1);
        check("held_start_result", uo_out, 8'h46);
        m_r = 8'h46;

        load(0, 0, 8'h21); load(1, 0, 8'h10);
        do_op(0, 0, 1); check("midload_res", uo_out, 8'h31);
        do_op(0, 0, 0); check("midload_a_kept", uo_out, 8'h31);

`ifdef SERIAL_ADDER_SUB_EN
        load(0, 0, 8'h05); load(1, 0, 8'h07); do_op(0, 1, 0);
        check("sub_0507", {uio_out[7:6], uo_out}, {2'b00, 8'hFE});
        load(0, 0, 8'h80); load(1, 0, 8'h01); do_op(0, 1, 0);
        check("sub_8001", {uio_out[7:6], uo_out}, {2'b11, 8'h7F});
`endif

        for (int i = 0; i < 25; i++) begin
            logic [7:0] va, vb;
            va = 8'($urandom);
            vb = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin load(0, 0, va); load(1, 0, vb); end
                1: load(0, 0, va);
                2: load(1, 0, vb);
                default: load(0, 1, va);
            endcase
            do_op(1'($urandom), 1'($urandom), 1'($urandom));
        end

        load(0, 0, 8'h33); load(1, 0, 8'h44);
        @(negedge clk);
        uio_in = 8'h01;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_uo", uo_out, 8'h00);
        check("midrst_uio", uio_out, 8'h00);
        check("midrst_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = 0; m_b = 0; m_r = 0; m_c = 0; m_v = 0;
        do_op(0, 0, 0);
        check("post_rst_zero", uo_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
